addsub_pipe: RTL and testbench
==============================

// Module: addsub_pipe
// PURPOSE
//  Parametrised, pipelined two's-complement adder/subtractor; successor to the 32-bit combinational full adder.
//  Splits a WIDTH-bit add into STAGES chunk-adders of CHUNK bits, one register stage per chunk, carry rippling stage to stage.
//  Adds subtract mode, signed-overflow/zero/negative flags and a valid/ready handshake with backpressure.
//  Sits between operand-select logic and ALU result mux; sustains one op/cycle when out_ready is high.
// PARAMETERS
//  WIDTH   32  operand/result width; must be a multiple of CHUNK
//  CHUNK   8   bits added per pipeline stage; STAGES = WIDTH/CHUNK (1 => single-register adder)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      A/B/Cin/Sub valid this cycle
//  in_ready   out  1      block accepts operands this cycle
//  A          in   WIDTH  operand A
//  B          in   WIDTH  operand B
//  Cin        in   1      carry-in (add) / borrow-in (sub)
//  Sub        in   1      0: Sum = A + B + Cin;  1: Sum = A - B - Cin
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts result
//  Sum        out  WIDTH  result, modulo 2**WIDTH
//  Cout       out  1      carry out of MSB of A + B' + c0 (sub: 1 = no borrow)
//  Ovf        out  1      signed overflow
//  Zero       out  1      Sum == 0
//  Neg        out  1      Sum[WIDTH-1]
// BEHAVIOUR
//  - Reset: out_valid=0, Sum=0, Cout=0, Ovf=0, Zero=0, Neg=0, all stage valids cleared; in_ready=1 in the first cycle after reset.
//  - Operand prep at accept: B' = Sub ? ~B : B; c0 = Sub ? ~Cin : Cin.
//  - Stage k (0..STAGES-1) adds A[k*CHUNK+:CHUNK] + B'[same] + carry from stage k-1 (c0 for k=0).
//    Upper operand chunks are carried forward in skew registers; completed lower sum chunks are carried forward in deskew registers.
//  - Latency: exactly STAGES cycles from accept (in_valid & in_ready) to out_valid, with no stalls.
//  - Throughput: one op/cycle. Global advance: adv = !out_valid | out_ready; in_ready = adv.
//    Every stage register and valid bit loads only when adv=1; otherwise all hold. No bubble collapsing.
//  - Output hold: while out_valid & !out_ready, Sum/Cout/flags/out_valid stay stable.
//  - Flags are computed in the last stage from final values:
//    Ovf = (A[MSB]==B'[MSB]) & (Sum[MSB]!=A[MSB]); Zero = ~|Sum; Neg = Sum[MSB].
//  - in_valid=0 while adv=1 inserts a bubble: the stage valid goes to 0; data registers may update (don't-care).
//  - Ops complete in order; there is no reordering and no drop.
//  - Reset mid-operation discards all in-flight ops; no output is produced for them.
//  - Wrap-around: the sum is modulo 2**WIDTH; the carry out of the MSB is reported only on Cout.
//  - Illegal parameters (WIDTH % CHUNK != 0, CHUNK < 1) stop elaboration with $error.
// STRUCTURE
//  - Package alu_pkg: typedef op_e {OP_ADD=1'b0, OP_SUB=1'b1}; struct flags_t {cout, ovf, zero, neg}.
//  - Sub-module chunk_adder #(CHUNK): combinational {co,s} = a + b + ci.
//    It is instantiated STAGES times in a generate loop; the top holds all pipeline, skew and handshake registers.
//  - No other hierarchy. Target size is 150-250 lines.
// TESTING  (WIDTH=32, CHUNK=8 unless noted; results checked against a reference model {Cout,Sum} = A + B' + c0)
//  1 add, no carry: A=ff000f0f B=00fff0f0 Cin=0 Sub=0 -> after 4 cycles Sum=ffffffff Cout=0 Ovf=0 Neg=1 Zero=0
//  2 add, ripple through all chunks: A=35355353 B=cacaacac Cin=1 -> Sum=00000000 Cout=1 Zero=1 Ovf=0
//  3 sub / overflow: A=80000000 B=00000001 Cin=0 Sub=1 -> Sum=7fffffff Cout=1 Ovf=1 Neg=0;
//    also A=00000002 B=00000003 Sub=1 -> Sum=ffffffff Cout=0 (borrow) Neg=1
//  4 backpressure: stream 10 random ops with out_ready toggling 1,0,0,1,...
//    -> results arrive in order, none lost or duplicated; outputs stable while stalled; in_ready==(!out_valid|out_ready)
//  5 reset mid-flight: accept 3 ops, assert rst for 1 cycle
//    -> out_valid=0 and all outputs 0 next cycle; no stale results after reset; next op returns after 4 cycles
//  6 parameter sweep: (WIDTH,CHUNK) = (8,8), (16,4), (64,16), 1000 random ops each
//    -> matches model; latency = WIDTH/CHUNK

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU datapath: operation select and result flag bundle.
package alu_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    typedef struct packed {
        logic cout;
        logic ovf;
        logic zero;
        logic neg;
    } flags_t;

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit adder slice with carry in and carry out.
module chunk_adder #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);

    logic [CHUNK:0] total;

    assign total   = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
    assign {co, s} = total;

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined two's-complement adder/subtractor: one CHUNK-bit slice per stage,
// carry rippling stage to stage, with a global-stall valid/ready handshake.
module addsub_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf,
    output logic             Zero,
    output logic             Neg
);

    localparam int SAFE_CHUNK = (CHUNK < 1) ? 1 : CHUNK;
    localparam int STAGES     = WIDTH / SAFE_CHUNK;
    localparam int MSB        = WIDTH - 1;

    if ((CHUNK < 1) || ((WIDTH % SAFE_CHUNK) != 0) || (STAGES < 1)) begin : g_param_check
        $error("addsub_pipe: WIDTH must be a positive multiple of CHUNK");
    end

    op_e             op;
    logic [WIDTH-1:0] bPrep;
    logic             c0;
    logic             adv;

    // Subtraction is A + ~B + ~Cin, so Cout=1 means "no borrow".
    assign op       = op_e'(Sub);
    assign bPrep    = (op == OP_SUB) ? ~B : B;
    assign c0       = (op == OP_SUB) ? ~Cin : Cin;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    logic [WIDTH-1:0] skewA   [STAGES];
    logic [WIDTH-1:0] skewB   [STAGES];
    logic [WIDTH-1:0] partSum [STAGES];
    logic             carry   [STAGES];
    logic             valid   [STAGES];

    logic [WIDTH-1:0] stA     [STAGES];
    logic [WIDTH-1:0] stB     [STAGES];
    logic [WIDTH-1:0] stSum   [STAGES];
    logic             stC     [STAGES];
    logic             stV     [STAGES];
    logic [WIDTH-1:0] nextSum [STAGES];
    logic [CHUNK-1:0] chunkSum [STAGES];
    logic             chunkCo  [STAGES];

    flags_t flagNext;
    flags_t flagReg;

    // Stage 0 takes fresh operands; later stages take the previous stage's registers.
    always_comb begin
        for (int i = 0; i < STAGES; i++) begin
            if (i == 0) begin
                stA[i]   = A;
                stB[i]   = bPrep;
                stSum[i] = '0;
                stC[i]   = c0;
                stV[i]   = in_valid;
            end else begin
                stA[i]   = skewA[i-1];
                stB[i]   = skewB[i-1];
                stSum[i] = partSum[i-1];
                stC[i]   = carry[i-1];
                stV[i]   = valid[i-1];
            end
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        chunk_adder #(.CHUNK(CHUNK)) u_chunk (
            .a  (stA[k][k*CHUNK +: CHUNK]),
            .b  (stB[k][k*CHUNK +: CHUNK]),
            .ci (stC[k]),
            .s  (chunkSum[k]),
            .co (chunkCo[k])
        );
    end

    always_comb begin
        for (int i = 0; i < STAGES; i++) begin
            nextSum[i] = stSum[i];
            nextSum[i][i*CHUNK +: CHUNK] = chunkSum[i];
        end
    end

    // Flags come from the completed sum and the top operand bits in the last stage.
    always_comb begin
        flagNext      = '0;
        flagNext.cout = chunkCo[STAGES-1];
        flagNext.ovf  = (stA[STAGES-1][MSB] == stB[STAGES-1][MSB]) &&
                        (nextSum[STAGES-1][MSB] != stA[STAGES-1][MSB]);
        flagNext.zero = ~|nextSum[STAGES-1];
        flagNext.neg  = nextSum[STAGES-1][MSB];
    end

    // One global advance: every stage moves together or everything holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                skewA[i]   <= '0;
                skewB[i]   <= '0;
                partSum[i] <= '0;
                carry[i]   <= 1'b0;
                valid[i]   <= 1'b0;
            end
            flagReg <= '0;
        end else if (adv) begin
            for (int i = 0; i < STAGES; i++) begin
                skewA[i]   <= stA[i];
                skewB[i]   <= stB[i];
                partSum[i] <= nextSum[i];
                carry[i]   <= chunkCo[i];
                valid[i]   <= stV[i];
            end
            flagReg <= flagNext;
        end
    end

    assign out_valid = valid[STAGES-1];
    assign Sum       = partSum[STAGES-1];
    assign Cout      = flagReg.cout;
    assign Ovf       = flagReg.ovf;
    assign Zero      = flagReg.zero;
    assign Neg       = flagReg.neg;

endmodule

// File: tb/tb_addsub_pipe.sv
// Self-checking bench for addsub_pipe: directed cases, backpressure, reset
// mid-flight and a parameter sweep against an arithmetic reference model.
module tb_addsub_pipe;

    localparam int NI = 4;

    typedef struct {
        logic [63:0] sum;
        logic [3:0]  flags;
        int          acceptCyc;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int widths [NI] = '{32, 8, 16, 64};
    int chunks [NI] = '{8, 8, 4, 16};

    logic        inValid  [NI];
    logic        outReady [NI];
    logic        cinIn    [NI];
    logic        subIn    [NI];
    logic [63:0] aIn      [NI];
    logic [63:0] bIn      [NI];
    logic        inReady  [NI];
    logic        outValid [NI];
    logic        coutO    [NI];
    logic        ovfO     [NI];
    logic        zeroO    [NI];
    logic        negO     [NI];
    logic [63:0] sumOut   [NI];

    logic [31:0] sum0;
    logic [7:0]  sum1;
    logic [15:0] sum2;
    logic [63:0] sum3;

    assign sumOut[0] = {32'b0, sum0};
    assign sumOut[1] = {56'b0, sum1};
    assign sumOut[2] = {48'b0, sum2};
    assign sumOut[3] = sum3;

    int checks   = 0;
    int failures = 0;

    addsub_pipe #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk), .rst(rst), .in_valid(inValid[0]), .in_ready(inReady[0]),
        .A(aIn[0][31:0]), .B(bIn[0][31:0]), .Cin(cinIn[0]), .Sub(subIn[0]),
        .out_valid(outValid[0]), .out_ready(outReady[0]), .Sum(sum0),
        .Cout(coutO[0]), .Ovf(ovfO[0]), .Zero(zeroO[0]), .Neg(negO[0])
    );

    addsub_pipe #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(inValid[1]), .in_ready(inReady[1]),
        .A(aIn[1][7:0]), .B(bIn[1][7:0]), .Cin(cinIn[1]), .Sub(subIn[1]),
        .out_valid(outValid[1]), .out_ready(outReady[1]), .Sum(sum1),
        .Cout(coutO[1]), .Ovf(ovfO[1]), .Zero(zeroO[1]), .Neg(negO[1])
    );

    addsub_pipe #(.WIDTH(16), .CHUNK(4)) dut16 (
        .clk(clk), .rst(rst), .in_valid(inValid[2]), .in_ready(inReady[2]),
        .A(aIn[2][15:0]), .B(bIn[2][15:0]), .Cin(cinIn[2]), .Sub(subIn[2]),
        .out_valid(outValid[2]), .out_ready(outReady[2]), .Sum(sum2),
        .Cout(coutO[2]), .Ovf(ovfO[2]), .Zero(zeroO[2]), .Neg(negO[2])
    );

    addsub_pipe #(.WIDTH(64), .CHUNK(16)) dut64 (
        .clk(clk), .rst(rst), .in_valid(inValid[3]), .in_ready(inReady[3]),
        .A(aIn[3]), .B(bIn[3]), .Cin(cinIn[3]), .Sub(subIn[3]),
        .out_valid(outValid[3]), .out_ready(outReady[3]), .Sum(sum3),
        .Cout(coutO[3]), .Ovf(ovfO[3]), .Zero(zeroO[3]), .Neg(negO[3])
    );

    function automatic logic [63:0] widthMask(input int w);
        return (w == 64) ? 64'hffff_ffff_ffff_ffff : ((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic signed [127:0] toSigned(input logic [63:0] v, input int w);
        logic signed [127:0] r;
        r = {64'b0, v};
        if (v[w-1]) r = r - (128'sd1 <<< w);
        return r;
    endfunction

    // Reference: true signed/unsigned arithmetic, then reduce to w bits.
    function automatic res_t refModel(input int w, input logic [63:0] a, input logic [63:0] b,
                                      input logic cin, input logic sub);
        res_t r;
        logic signed [127:0] sa, sb, sc, total, maxv, minv;
        logic [127:0] ua, ub, uc;
        logic [63:0] mask;
        logic cout;
        mask  = widthMask(w);
        sa    = toSigned(a & mask, w);
        sb    = toSigned(b & mask, w);
        sc    = {127'b0, cin};
        total = sub ? (sa - sb - sc) : (sa + sb + sc);
        maxv  = (128'sd1 <<< (w - 1)) - 128'sd1;
        minv  = -(128'sd1 <<< (w - 1));
        ua    = {64'b0, a & mask};
        ub    = {64'b0, b & mask};
        uc    = {127'b0, cin};
        cout  = sub ? (ua >= ub + uc) : (((ua + ub + uc) >> w) != 128'd0);
        r.sum = total[63:0] & mask;
        r.flags = {cout, (total > maxv) || (total < minv), r.sum == 64'd0, r.sum[w-1]};
        r.acceptCyc = 0;
        return r;
    endfunction

    task automatic checkValue(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b, input logic cin, input logic sub);
        int waitCyc;
        @(negedge clk);
        aIn[0]      = a;
        bIn[0]      = b;
        cinIn[0]    = cin;
        subIn[0]    = sub;
        inValid[0]  = 1'b1;
        outReady[0] = 1'b1;
        #1;
        waitCyc = 0;
        while (!inReady[0] && waitCyc < 20) begin
            @(negedge clk);
            #1;
            waitCyc++;
        end
        checkValue("apply.in_ready", 64'(inReady[0]), 64'd1);
        @(posedge clk);
        #1;
        inValid[0] = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] expSum, input logic [3:0] expFlags);
        int lat;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!outValid[0] && lat < 20);
        checkValue({tag, ".latency"}, 64'(lat), 64'd4);
        checkValue({tag, ".sum"}, sumOut[0], expSum);
        checkValue({tag, ".flags"}, {60'b0, coutO[0], ovfO[0], zeroO[0], negO[0]}, {60'b0, expFlags});
    endtask

    // mode 0: out_ready always 1 (exact latency); 1: ready pattern 1,0,0; 2: random ready
    task automatic runStream(input int idx, input int nOps, input int mode, input string tag);
        res_t q[$];
        res_t e;
        int w, stages, sent, got, cyc;
        logic [63:0] mask, heldSum;
        logic [4:0]  heldCtl;
        logic prevStall, pending;
        w = widths[idx];
        stages = w / chunks[idx];
        mask = widthMask(w);
        sent = 0; got = 0; cyc = 0;
        prevStall = 1'b0; pending = 1'b0;
        heldSum = '0; heldCtl = '0;
        while (got < nOps && cyc < nOps * 10 + 100) begin
            @(negedge clk);
            if (prevStall) begin
                checkValue({tag, ".hold_sum"}, sumOut[idx], heldSum);
                checkValue({tag, ".hold_ctl"},
                           {59'b0, outValid[idx], coutO[idx], ovfO[idx], zeroO[idx], negO[idx]},
                           {59'b0, heldCtl});
            end
            if (!pending) begin
                inValid[idx] = (sent < nOps) && ($urandom_range(3) != 0);
                aIn[idx]     = {$urandom, $urandom} & mask;
                bIn[idx]     = {$urandom, $urandom} & mask;
                cinIn[idx]   = 1'($urandom);
                subIn[idx]   = 1'($urandom);
            end
            case (mode)
                0:       outReady[idx] = 1'b1;
                1:       outReady[idx] = (cyc % 3 == 0);
                default: outReady[idx] = 1'($urandom);
            endcase
            #1;
            checkValue({tag, ".in_ready"}, 64'(inReady[idx]), 64'(!outValid[idx] || outReady[idx]));
            if (outValid[idx] && outReady[idx]) begin
                checkValue({tag, ".spurious"}, 64'(q.size() == 0), 64'd0);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    checkValue({tag, ".sum"}, sumOut[idx], e.sum);
                    checkValue({tag, ".flags"}, {60'b0, coutO[idx], ovfO[idx], zeroO[idx], negO[idx]},
                               {60'b0, e.flags});
                    if (mode == 0)
                        checkValue({tag, ".latency"}, 64'(cyc - e.acceptCyc), 64'(stages));
                    got++;
                end
            end
            if (inValid[idx] && inReady[idx]) begin
                e = refModel(w, aIn[idx], bIn[idx], cinIn[idx], subIn[idx]);
                e.acceptCyc = cyc;
                q.push_back(e);
                sent++;
            end
            pending   = inValid[idx] && !inReady[idx];
            prevStall = outValid[idx] && !outReady[idx];
            heldSum   = sumOut[idx];
            heldCtl   = {outValid[idx], coutO[idx], ovfO[idx], zeroO[idx], negO[idx]};
            cyc++;
        end
        checkValue({tag, ".count"}, 64'(got), 64'(nOps));
        @(negedge clk);
        inValid[idx]  = 1'b0;
        outReady[idx] = 1'b1;
    endtask

    initial begin
        res_t e;
        logic [63:0] ra, rb;
        for (int i = 0; i < NI; i++) begin
            inValid[i]  = 1'b0;
            outReady[i] = 1'b1;
            cinIn[i]    = 1'b0;
            subIn[i]    = 1'b0;
            aIn[i]      = '0;
            bIn[i]      = '0;
        end

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkValue("reset.out_valid", 64'(outValid[0]), 64'd0);
        checkValue("reset.sum", sumOut[0], 64'd0);
        checkValue("reset.flags", {60'b0, coutO[0], ovfO[0], zeroO[0], negO[0]}, 64'd0);
        checkValue("reset.in_ready", 64'(inReady[0]), 64'd1);

        $display("[TB] directed add/sub cases");
        applyStimulus(64'hff000f0f, 64'h00fff0f0, 1'b0, 1'b0);
        checkOutput("add_nocarry", 64'hffffffff, 4'b0001);
        applyStimulus(64'h35355353, 64'hcacaacac, 1'b1, 1'b0);
        checkOutput("add_ripple", 64'h00000000, 4'b1010);
        applyStimulus(64'h80000000, 64'h00000001, 1'b0, 1'b1);
        checkOutput("sub_ovf", 64'h7fffffff, 4'b1100);
        applyStimulus(64'h00000002, 64'h00000003, 1'b0, 1'b1);
        checkOutput("sub_borrow", 64'hffffffff, 4'b0001);

        $display("[TB] backpressure stream");
        runStream(0, 10, 1, "bp");
        runStream(0, 200, 2, "rand32");

        $display("[TB] reset mid-flight");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            aIn[0]      = {32'b0, $urandom};
            bIn[0]      = {32'b0, $urandom};
            cinIn[0]    = 1'($urandom);
            subIn[0]    = 1'($urandom);
            inValid[0]  = 1'b1;
            outReady[0] = 1'b1;
        end
        @(negedge clk);
        inValid[0] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkValue("midrst.out_valid", 64'(outValid[0]), 64'd0);
        checkValue("midrst.sum", sumOut[0], 64'd0);
        checkValue("midrst.flags", {60'b0, coutO[0], ovfO[0], zeroO[0], negO[0]}, 64'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkValue("midrst.stale", 64'(outValid[0]), 64'd0);
        end
        ra = {32'b0, $urandom};
        rb = {32'b0, $urandom};
        e = refModel(32, ra, rb, 1'b1, 1'b1);
        applyStimulus(ra, rb, 1'b1, 1'b1);
        checkOutput("midrst.next", e.sum, e.flags);

        $display("[TB] parameter sweep");
        runStream(1, 1000, 0, "w8c8");
        runStream(2, 1000, 0, "w16c4");
        runStream(3, 1000, 0, "w64c16");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
